// File: rtl/imm_encoder.sv
// Immediate encoder: splits 32-bit constants into the shortest sequence of
// immediate-field beats (format 0, format 1, or format-1 upper followed by a
// shift-merge format-0 lower) and keeps a saturating count of emitted beats.
module imm_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_value,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_imm_src,
  output logic [24:0] out_imm2,
  output logic        out_merge,
  output logic        out_last,
  input  logic        cnt_clr,
  output logic [15:0] beat_count
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] HI    = 2'd2;
  localparam logic [1:0] LO    = 2'd3;

  logic [1:0]  state;
  logic [14:0] lo_hold;
  logic        in_hs;
  logic        out_hs;
  logic        is_short;
  logic        is_mid;

  assign out_valid = (state != EMPTY);
  assign out_hs    = out_valid && out_ready;
  // Accept may coincide with the handshake of the final beat of a constant.
  assign in_ready  = (state == EMPTY) || (out_ready && out_last && out_valid);
  assign in_hs     = in_valid && in_ready;

  // Classify the incoming constant by its unsigned magnitude.
  always_comb begin
    is_short = (in_value[31:15] == '0);
    is_mid   = !is_short && (in_value[31:25] == '0);
  end

  // Beat sequencing: load a new constant's first beat, advance HI to LO,
  // or drain to EMPTY with all output fields cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= EMPTY;
      out_imm_src <= '0;
      out_imm2    <= '0;
      out_merge   <= 1'b0;
      out_last    <= 1'b0;
      lo_hold     <= '0;
    end else if (in_hs) begin
      if (is_short) begin
        state       <= ONE;
        out_imm_src <= 2'd0;
        out_imm2    <= {10'd0, in_value[14:0]};
        out_merge   <= 1'b0;
        out_last    <= 1'b1;
      end else if (is_mid) begin
        state       <= ONE;
        out_imm_src <= 2'd1;
        out_imm2    <= in_value[24:0];
        out_merge   <= 1'b0;
        out_last    <= 1'b1;
      end else begin
        state       <= HI;
        out_imm_src <= 2'd1;
        out_imm2    <= {8'd0, in_value[31:15]};
        out_merge   <= 1'b0;
        out_last    <= 1'b0;
        lo_hold     <= in_value[14:0];
      end
    end else if (out_hs) begin
      if (state == HI) begin
        state       <= LO;
        out_imm_src <= 2'd0;
        out_imm2    <= {10'd0, lo_hold};
        out_merge   <= 1'b1;
        out_last    <= 1'b1;
      end else begin
        state       <= EMPTY;
        out_imm_src <= '0;
        out_imm2    <= '0;
        out_merge   <= 1'b0;
        out_last    <= 1'b0;
      end
    end
  end

  // Saturating count of output handshakes; clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_count <= '0;
    end else if (cnt_clr) begin
      beat_count <= '0;
    end else if (out_hs && (beat_count != 16'hFFFF)) begin
      beat_count <= beat_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed cases plus randomized traffic
// against a queue-of-beats reference model.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_value;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_imm_src;
  logic [24:0] out_imm2;
  logic        out_merge;
  logic        out_last;
  logic        cnt_clr;
  logic [15:0] beat_count;

  imm_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_value   (in_value),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_imm_src(out_imm_src),
    .out_imm2   (out_imm2),
    .out_merge  (out_merge),
    .out_last   (out_last),
    .cnt_clr    (cnt_clr),
    .beat_count (beat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  src;
    logic [24:0] imm2;
    logic        merge;
    logic        last;
  } beat_t;

  beat_t       q[$];
  int unsigned model_cnt;
  int unsigned n_checks;
  int unsigned n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference: a constant becomes one or two beats by magnitude.
  function automatic void model_push(input logic [31:0] v);
    beat_t b;
    if (v < 32'd32768) begin
      b.src = 2'd0; b.imm2 = 25'(v); b.merge = 1'b0; b.last = 1'b1; q.push_back(b);
    end else if (v < 32'd33554432) begin
      b.src = 2'd1; b.imm2 = 25'(v); b.merge = 1'b0; b.last = 1'b1; q.push_back(b);
    end else begin
      b.src = 2'd1; b.imm2 = 25'(v / 32'd32768); b.merge = 1'b0; b.last = 1'b0; q.push_back(b);
      b.src = 2'd0; b.imm2 = 25'(v % 32'd32768); b.merge = 1'b1; b.last = 1'b1; q.push_back(b);
    end
  endfunction

  task automatic check_outputs();
    if (q.size() == 0) begin
      check("out_valid", {31'd0, out_valid}, 32'd0);
      check("idle_src", {30'd0, out_imm_src}, 32'd0);
      check("idle_imm2", {7'd0, out_imm2}, 32'd0);
      check("idle_merge_last", {30'd0, out_merge, out_last}, 32'd0);
    end else begin
      check("out_valid", {31'd0, out_valid}, 32'd1);
      check("out_imm_src", {30'd0, out_imm_src}, {30'd0, q[0].src});
      check("out_imm2", {7'd0, out_imm2}, {7'd0, q[0].imm2});
      check("out_merge", {31'd0, out_merge}, {31'd0, q[0].merge});
      check("out_last", {31'd0, out_last}, {31'd0, q[0].last});
    end
    check("beat_count", {16'd0, beat_count}, model_cnt);
  endtask

  // One clock cycle: drive, check in_ready, advance model, check outputs.
  task automatic step(input logic iv, input logic [31:0] val, input logic ordy, input logic clr);
    logic exp_rdy;
    in_valid = iv; in_value = val; out_ready = ordy; cnt_clr = clr;
    #1;
    exp_rdy = (q.size() == 0) || (ordy && q[0].last);
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    if (clr) model_cnt = 0;
    else if (ordy && q.size() > 0 && model_cnt < 65535) model_cnt++;
    if (ordy && q.size() > 0) void'(q.pop_front());
    if (iv && exp_rdy) model_push(val);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  function automatic logic [31:0] rand_value();
    case ($urandom_range(0, 3))
      0: return $urandom & 32'h0000_7FFF;
      1: return 32'h0000_8000 + $urandom_range(0, 32'h01FF_7FFF);
      2: return $urandom | 32'h0200_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    n_checks = 0; n_pass = 0; model_cnt = 0;
    rst = 1'b1; in_valid = 1'b0; in_value = '0; out_ready = 1'b0; cnt_clr = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_imm2", {7'd0, out_imm2}, 32'd0);
    check("rst_fields", {28'd0, out_imm_src, out_merge, out_last}, 32'd0);
    check("rst_count", {16'd0, beat_count}, 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Short constant.
    step(1'b1, 32'h0000_1234, 1'b1, 1'b0);
    check("short_imm2", {7'd0, out_imm2}, 32'h0001234);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("short_count", {16'd0, beat_count}, 32'd1);

    // Class boundaries back to back.
    step(1'b1, 32'h0000_7FFF, 1'b1, 1'b0);
    check("b0_src", {30'd0, out_imm_src}, 32'd0);
    step(1'b1, 32'h0000_8000, 1'b1, 1'b0);
    check("b1_src", {30'd0, out_imm_src}, 32'd1);
    check("b1_imm2", {7'd0, out_imm2}, 32'h0008000);
    step(1'b1, 32'h01FF_FFFF, 1'b1, 1'b0);
    check("b2_imm2", {7'd0, out_imm2}, 32'h1FFFFFF);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Long constant split.
    step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    check("longA_imm2", {7'd0, out_imm2}, 32'h001BD5B);
    check("longA_last", {31'd0, out_last}, 32'd0);
    step(1'b1, 32'h0000_0001, 1'b1, 1'b0);
    check("longB_imm2", {7'd0, out_imm2}, 32'h0003EEF);
    check("longB_merge", {31'd0, out_merge}, 32'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Long constant under backpressure.
    step(1'b1, 32'h0200_0000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h0000_0055, 1'b0, 1'b0);
      check("bp_imm2", {7'd0, out_imm2}, 32'h0000400);
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("bp_B_imm2", {7'd0, out_imm2}, 32'd0);
    check("bp_B_merge", {31'd0, out_merge}, 32'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Reset while beat A pending.
    step(1'b1, 32'h8000_0000, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_imm2", {7'd0, out_imm2}, 32'd0);
    check("arst_fields", {28'd0, out_imm_src, out_merge, out_last}, 32'd0);
    check("arst_count", {16'd0, beat_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    model_cnt = 0;
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 1)), rand_value(), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 63) == 0));

    // Saturation, then clear racing a handshake.
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 65537; i++) step(1'b1, $urandom & 32'h7FFF, 1'b1, 1'b0);
    check("sat_count", {16'd0, beat_count}, 32'h0000FFFF);
    step(1'b1, 32'h0000_0042, 1'b1, 1'b1);
    check("clr_count", {16'd0, beat_count}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Immediate encoder for the processor's constant-load path; it performs the inverse of the immediate extender. It takes 32-bit constants over a valid/ready handshake and emits the shortest sequence of immediate-field beats that the extender and datapath reconstruct exactly. The sequence is one beat in format 0 (15-bit zero-extended), one beat in format 1 (25-bit zero-extended), or two beats: a format-1 upper part followed by a shift-merge format-0 lower part. The block sits between the assembler/loader front end and the instruction builder, and also keeps a saturating count of emitted beats.

## Interface
- No parameters; all widths are fixed by the instruction immediate formats.
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  constant available on in_value
- in_value  in  32  constant to encode
- in_ready  out  1  encoder accepts in_value this cycle
- out_valid  out  1  beat available on the output fields
- out_ready  in  1  consumer takes the beat this cycle
- out_imm_src  out  2  extender format: 0 = imm2[14:0] zero-extended, 1 = imm2[24:0] zero-extended; 2 and 3 are never driven
- out_imm2  out  25  immediate field; bits above the format width are 0
- out_merge  out  1  consumer computes dest = (dest << 15) | extended value; when 0, dest = extended value
- out_last  out  1  final beat of this constant
- cnt_clr  in  1  synchronous clear of beat_count
- beat_count  out  16  completed output handshakes, saturating

## Operation
- Input handshake occurs when in_valid && in_ready. Output handshake occurs when out_valid && out_ready.
- Class decision, made on the unsigned input value at acceptance:
  - value < 2^15 (SHORT): one beat. imm_src=0, imm2={10'd0, value[14:0]}, merge=0, last=1.
  - 2^15 <= value < 2^25 (MID): one beat. imm_src=1, imm2=value[24:0], merge=0, last=1.
  - value >= 2^25 (LONG): two beats.
    - Beat A: imm_src=1, imm2={8'd0, value[31:15]}, merge=0, last=0.
    - Beat B: imm_src=0, imm2={10'd0, value[14:0]}, merge=1, last=1.
- State machine: EMPTY, ONE (holding a SHORT/MID beat), HI (holding LONG beat A), LO (holding LONG beat B).
  - EMPTY: accept moves to ONE or HI.
  - ONE: output handshake with a simultaneous accept moves to ONE or HI; output handshake alone moves to EMPTY.
  - HI: output handshake moves to LO. No acceptance is possible in HI.
  - LO: output handshake with a simultaneous accept moves to ONE or HI; output handshake alone moves to EMPTY.
- in_ready = (state==EMPTY) || (out_ready && out_last && out_valid). This is combinational from out_ready, so an accept can coincide with the handshake of the last beat.
- A LONG value's low 15 bits are held internally from acceptance until beat B is loaded.
- Output fields are registered and stay stable while out_valid && !out_ready. Fields are don't-care-free: in EMPTY they read 0.
- beat_count increments by 1 on each output handshake and holds at 0xFFFF.
  - cnt_clr forces it to 0.
  - cnt_clr has priority over an increment in the same cycle.

## Timing
- Reset values: state=EMPTY, out_valid=0, out_imm_src=0, out_imm2=0, out_merge=0, out_last=0, beat_count=0.
- in_ready is 1 in the cycle after reset deasserts.
- Latency: a constant accepted at edge t presents its first beat with out_valid=1 after edge t. Beat B of a LONG value appears the cycle after beat A's handshake.
- Throughput with out_ready held at 1:
  - SHORT/MID: one constant per cycle.
  - LONG: one constant per two cycles.
- Backpressure: with out_ready=0 the beat holds indefinitely and in_ready=0, except in EMPTY.
- Reset mid-operation: the pending beat and the held low part are discarded, outputs return to reset values asynchronously, and no partial sequence resumes.
- Changes on in_value when not accepted have no effect.

## Test plan
- Accept 0x00001234 with out_ready=1 -> next cycle: one beat, src=0, imm2=0x0001234, merge=0, last=1; beat_count=1.
- Boundaries: accept 0x00007FFF, then 0x00008000, then 0x01FFFFFF back-to-back ->
  - src 0/imm2 0x0007FFF
  - src 1/imm2 0x0008000
  - src 1/imm2 0x1FFFFFF
  - one beat per cycle, in_ready stays 1
- Accept 0xDEADBEEF ->
  - beat A: src=1, imm2=0x001BD5B, merge=0, last=0
  - then beat B: src=0, imm2=0x0003EEF, merge=1, last=1
  - in_ready=0 during beat A
- Accept 0x02000000 while holding out_ready=0 for 3 cycles -> beat A (imm2=0x0000400) is stable throughout and in_ready=0; after release, beat B has imm2=0 and merge=1.
- Accept 0x80000000, assert rst while beat A is pending -> all outputs are 0 immediately and no beat B appears after rst drops.
- Drive 65537 handshakes -> beat_count=0xFFFF. Then cnt_clr together with a handshake -> beat_count=0.
